// File: rtl/snake_pkg.sv
// Shared definitions for the snake game display path: matrix geometry,
// row word type and the scanner FSM state encoding.
package snake_pkg;
   localparam int unsigned MATRIX_ROWS = 16;
   localparam int unsigned MATRIX_COLS = 16;
   localparam int unsigned ROW_IDX_W   = $clog2(MATRIX_ROWS);
   localparam int unsigned BIT_IDX_W   = $clog2(MATRIX_COLS);

   typedef logic [MATRIX_COLS-1:0] row_word_t;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2,
      ST_HOLD  = 2'd3
   } scan_state_t;
endpackage

// File: rtl/led_matrix_scanner_if.sv
// Game-core write/swap port plus the serial 74HC595 drive lines of the scanner.
interface led_matrix_scanner_if;
   import snake_pkg::*;

   logic                 wr_en;
   logic [ROW_IDX_W-1:0] wr_row;
   row_word_t            wr_data;
   logic                 swap_req;
   logic                 swap_ack;
   logic                 frame_start;
   logic                 SER_COL;
   logic                 SER_ROW;
   logic                 SRCLK;
   logic                 RCLK;
   logic                 OE_N;

   modport master (
      output wr_en, wr_row, wr_data, swap_req,
      input  swap_ack, frame_start, SER_COL, SER_ROW, SRCLK, RCLK, OE_N
   );

   modport slave (
      input  wr_en, wr_row, wr_data, swap_req,
      output swap_ack, frame_start, SER_COL, SER_ROW, SRCLK, RCLK, OE_N
   );
endinterface

// File: rtl/matrix_tick_gen.sv
// Phase timer for the scanner: reloads with DIV or HOLD and flags the last
// cycle of the phase.
module matrix_tick_gen #(
   parameter int unsigned DIV  = 25,
   parameter int unsigned HOLD = 49174
) (
   input  logic CLK1_50,
   input  logic CLR,
   input  logic load,
   input  logic sel_hold,
   output logic done_c
);
   localparam int unsigned MAX_LEN = (DIV > HOLD) ? DIV : HOLD;
   localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [CNT_W-1:0] cnt;

   // Counter holds the number of cycles left in the phase after this one.
   always_ff @(posedge CLK1_50 or posedge CLR) begin
      if (CLR) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= sel_hold ? CNT_W'(HOLD - 1) : CNT_W'(DIV - 1);
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign done_c = (cnt == '0);
endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered 16x16 LED matrix scan driver feeding two daisy-chained
// 74HC595 chains; front/back swaps only happen at frame boundaries.
module led_matrix_scanner
   import snake_pkg::*;
#(
   parameter int unsigned DIV  = 25,
   parameter int unsigned HOLD = 49174
) (
   input  logic                 CLK1_50,
   input  logic                 CLR,
   led_matrix_scanner_if.slave  bus
);
   localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(MATRIX_ROWS - 1);
   localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(MATRIX_COLS - 1);

   logic [1:0][MATRIX_ROWS-1:0][MATRIX_COLS-1:0] bufs;

   scan_state_t          state, state_d;
   logic                 front, front_d;
   logic [ROW_IDX_W-1:0] row, row_d;
   logic                 pending, pending_d;
   row_word_t            col_word, col_word_d;
   row_word_t            row_word, row_word_d;
   logic [BIT_IDX_W-1:0] bit_cnt, bit_cnt_d;
   logic                 half, half_d;
   logic                 srclk, srclk_d;
   logic                 rclk, rclk_d;
   logic                 ser_col, ser_col_d;
   logic                 ser_row, ser_row_d;
   logic                 oe_n, oe_n_d;
   logic                 swap_ack, swap_ack_d;
   logic                 frame_start, frame_start_d;
   logic                 tick_load_c, tick_hold_c, tick_done_c;

   matrix_tick_gen #(.DIV(DIV), .HOLD(HOLD)) u_tick (
      .CLK1_50  (CLK1_50),
      .CLR      (CLR),
      .load     (tick_load_c),
      .sel_hold (tick_hold_c),
      .done_c   (tick_done_c)
   );

   // Game writes always land in the buffer not being scanned.
   always_ff @(posedge CLK1_50 or posedge CLR) begin
      if (CLR) begin
         bufs <= '0;
      end else if (bus.wr_en) begin
         bufs[!front][bus.wr_row] <= bus.wr_data;
      end
   end

   always_ff @(posedge CLK1_50 or posedge CLR) begin
      if (CLR) begin
         state       <= ST_LOAD;
         front       <= 1'b0;
         row         <= '0;
         pending     <= 1'b0;
         col_word    <= '0;
         row_word    <= '0;
         bit_cnt     <= '0;
         half        <= 1'b0;
         srclk       <= 1'b0;
         rclk        <= 1'b0;
         ser_col     <= 1'b0;
         ser_row     <= 1'b0;
         oe_n        <= 1'b1;
         swap_ack    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_d;
         front       <= front_d;
         row         <= row_d;
         pending     <= pending_d;
         col_word    <= col_word_d;
         row_word    <= row_word_d;
         bit_cnt     <= bit_cnt_d;
         half        <= half_d;
         srclk       <= srclk_d;
         rclk        <= rclk_d;
         ser_col     <= ser_col_d;
         ser_row     <= ser_row_d;
         oe_n        <= oe_n_d;
         swap_ack    <= swap_ack_d;
         frame_start <= frame_start_d;
      end
   end

   always_comb begin
      state_d       = state;
      front_d       = front;
      row_d         = row;
      pending_d     = pending | bus.swap_req;
      col_word_d    = col_word;
      row_word_d    = row_word;
      bit_cnt_d     = bit_cnt;
      half_d        = half;
      srclk_d       = srclk;
      rclk_d        = rclk;
      ser_col_d     = ser_col;
      ser_row_d     = ser_row;
      oe_n_d        = oe_n;
      swap_ack_d    = 1'b0;
      frame_start_d = 1'b0;
      tick_load_c   = 1'b0;
      tick_hold_c   = 1'b0;

      case (state)
         ST_LOAD: begin
            col_word_d    = bufs[front][row];
            row_word_d    = row_word_t'(1) << row;
            ser_col_d     = col_word_d[MATRIX_COLS-1];
            ser_row_d     = row_word_d[MATRIX_COLS-1];
            bit_cnt_d     = '0;
            half_d        = 1'b0;
            srclk_d       = 1'b0;
            frame_start_d = (row == '0);
            tick_load_c   = 1'b1;
            state_d       = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (tick_done_c) begin
               tick_load_c = 1'b1;
               if (!half) begin
                  srclk_d = 1'b1;
                  half_d  = 1'b1;
               end else begin
                  srclk_d = 1'b0;
                  half_d  = 1'b0;
                  if (bit_cnt == LAST_BIT) begin
                     rclk_d  = 1'b1;
                     state_d = ST_LATCH;
                  end else begin
                     // Next bit is presented together with the SRCLK fall.
                     bit_cnt_d  = bit_cnt + BIT_IDX_W'(1);
                     col_word_d = col_word << 1;
                     row_word_d = row_word << 1;
                     ser_col_d  = col_word[MATRIX_COLS-2];
                     ser_row_d  = row_word[MATRIX_COLS-2];
                  end
               end
            end
         end
         ST_LATCH: begin
            if (tick_done_c) begin
               rclk_d      = 1'b0;
               oe_n_d      = 1'b0;
               tick_load_c = 1'b1;
               tick_hold_c = 1'b1;
               state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (tick_done_c) begin
               row_d   = row + ROW_IDX_W'(1);
               state_d = ST_LOAD;
               // Frame boundary: a request seen this very cycle arms the next frame.
               if (row == LAST_ROW && pending) begin
                  front_d    = !front;
                  swap_ack_d = 1'b1;
                  pending_d  = bus.swap_req;
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   assign bus.swap_ack    = swap_ack;
   assign bus.frame_start = frame_start;
   assign bus.SER_COL     = ser_col;
   assign bus.SER_ROW     = ser_row;
   assign bus.SRCLK       = srclk;
   assign bus.RCLK        = rclk;
   assign bus.OE_N        = oe_n;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: decodes the serial stream row by row and
// compares it to a frame-level model of the double buffer.
module tb_led_matrix_scanner;
   import snake_pkg::*;

   localparam int unsigned DIV          = 2;
   localparam int unsigned HOLD         = 4;
   localparam int unsigned ROW_PERIOD   = 1 + 32 * DIV + DIV + HOLD;
   localparam int unsigned FRAME_PERIOD = 16 * ROW_PERIOD;

   logic CLK1_50 = 1'b0;
   logic CLR;

   led_matrix_scanner_if bus ();

   led_matrix_scanner #(.DIV(DIV), .HOLD(HOLD)) dut (
      .CLK1_50 (CLK1_50),
      .CLR     (CLR),
      .bus     (bus)
   );

   always #5 CLK1_50 = ~CLK1_50;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int unsigned fs_last = 0;
   int unsigned fs_gap = 0;
   bit          fs_valid = 1'b0;
   bit          fs_seen_row = 1'b0;
   int          acks = 0;
   int          frames = 0;

   logic [15:0] m_buf [2][16];
   bit          m_front;
   bit          m_pending;
   int          m_row;
   bit          first_latch;
   logic [15:0] cap_col [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock, sampled on the falling edge; tracks pulse outputs.
   task automatic tick();
      @(negedge CLK1_50);
      cyc++;
      if (bus.swap_ack === 1'b1) acks++;
      if (bus.frame_start === 1'b1) begin
         fs_seen_row = 1'b1;
         if (fs_valid) fs_gap = cyc - fs_last;
         fs_last  = cyc;
         fs_valid = 1'b1;
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 16; r++) m_buf[b][r] = 16'h0;
      m_front     = 1'b0;
      m_pending   = 1'b0;
      m_row       = 0;
      first_latch = 1'b1;
      fs_valid    = 1'b0;
      frames      = 0;
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_srclk"},    32'(bus.SRCLK),       32'(0));
      chk({pfx, "_rclk"},     32'(bus.RCLK),        32'(0));
      chk({pfx, "_ser_col"},  32'(bus.SER_COL),     32'(0));
      chk({pfx, "_ser_row"},  32'(bus.SER_ROW),     32'(0));
      chk({pfx, "_swap_ack"}, 32'(bus.swap_ack),    32'(0));
      chk({pfx, "_fstart"},   32'(bus.frame_start), 32'(0));
      chk({pfx, "_oe_n"},     32'(bus.OE_N),        32'(1));
   endtask

   task automatic capture_row(output logic [15:0] col, output logic [15:0] rsel,
                              output int rises, output int rclk_hi,
                              output logic oe_hi, output bit done);
      logic prev_sr, prev_rc;
      col = '0; rsel = '0; rises = 0; rclk_hi = 0; oe_hi = 1'bx; done = 1'b0;
      fs_seen_row = 1'b0;
      prev_sr = bus.SRCLK;
      prev_rc = bus.RCLK;
      for (int i = 0; i < 4 * int'(ROW_PERIOD) && !done; i++) begin
         tick();
         if (bus.SRCLK === 1'b1 && prev_sr === 1'b0) begin
            col  = {col[14:0], bus.SER_COL};
            rsel = {rsel[14:0], bus.SER_ROW};
            rises++;
         end
         if (bus.RCLK === 1'b1) begin
            rclk_hi++;
            oe_hi = bus.OE_N;
         end
         if (bus.RCLK === 1'b0 && prev_rc === 1'b1) done = 1'b1;
         prev_sr = bus.SRCLK;
         prev_rc = bus.RCLK;
      end
   endtask

   // Scan one row, then apply an optional write/swap request in its hold time
   // (for row 15 the request lands exactly in the frame-boundary cycle).
   task automatic run_row(input bit do_wr, input logic [3:0] wr_r,
                          input logic [15:0] wr_d, input bit do_swap);
      logic [15:0] col, rsel;
      int rises, rclk_hi;
      logic oe_hi;
      bit done;
      logic [15:0] exp_rsel;
      capture_row(col, rsel, rises, rclk_hi, oe_hi, done);
      exp_rsel = 16'h1 << m_row;
      chk("row_latched", 32'(done), 32'(1));
      chk($sformatf("row%0d_col", m_row), 32'(col), 32'(m_buf[m_front][m_row]));
      chk($sformatf("row%0d_sel", m_row), 32'(rsel), 32'(exp_rsel));
      chk("srclk_rises", 32'(rises), 32'(16));
      chk("rclk_width", 32'(rclk_hi), DIV);
      chk("frame_start_row0", 32'(fs_seen_row), 32'(m_row == 0));
      if (first_latch) begin
         chk("oe_n_before_latch", 32'(oe_hi), 32'(1));
         chk("oe_n_after_latch", 32'(bus.OE_N), 32'(0));
         first_latch = 1'b0;
      end else begin
         chk("oe_n_enabled", 32'(oe_hi), 32'(0));
      end
      cap_col[m_row] = col;
      if (m_row != 15) begin
         bus.wr_en = do_wr; bus.wr_row = wr_r; bus.wr_data = wr_d; bus.swap_req = do_swap;
         tick();
         bus.wr_en = 1'b0; bus.swap_req = 1'b0;
         if (do_wr) m_buf[!m_front][wr_r] = wr_d;
         if (do_swap) m_pending = 1'b1;
         m_row++;
      end else begin
         repeat (HOLD - 1) tick();
         bus.wr_en = do_wr; bus.wr_row = wr_r; bus.wr_data = wr_d; bus.swap_req = do_swap;
         tick();
         bus.wr_en = 1'b0; bus.swap_req = 1'b0;
         chk("swap_ack_at_boundary", 32'(bus.swap_ack), 32'(m_pending));
         if (do_wr) m_buf[!m_front][wr_r] = wr_d;
         if (m_pending) m_front = !m_front;
         m_pending = do_swap;
         m_row = 0;
      end
   endtask

   // wr_mode: 0 none, 1 random, 2 fill every row with 0xFFFF.
   task automatic run_frame(input int wr_mode, input int d_at, input logic [3:0] d_row,
                            input logic [15:0] d_data, input logic [15:0] swap_mask,
                            input bit b_swap, input bit b_wr, input logic [3:0] b_row,
                            input logic [15:0] b_data);
      int exp_acks;
      acks = 0;
      exp_acks = 0;
      for (int r = 0; r < 16; r++) begin
         bit w, s;
         logic [3:0] wr;
         logic [15:0] wd;
         w = 1'b0; wr = 4'(r); wd = 16'h0; s = swap_mask[r];
         if (wr_mode == 1) begin
            w = ($urandom_range(0, 1) == 1); wr = 4'($urandom_range(0, 15)); wd = 16'($urandom);
         end else if (wr_mode == 2) begin
            w = 1'b1; wr = 4'(r); wd = 16'hFFFF;
         end
         if (r == d_at) begin w = 1'b1; wr = d_row; wd = d_data; end
         if (r == 15) begin
            s = b_swap;
            if (b_wr) begin w = 1'b1; wr = b_row; wd = b_data; end
            exp_acks = int'(m_pending);
         end
         run_row(w, wr, wd, s);
      end
      chk("swap_ack_count", 32'(acks), 32'(exp_acks));
      frames++;
      if (frames >= 2) chk("frame_period", fs_gap, FRAME_PERIOD);
   endtask

   initial begin
      int rises;
      logic prev_sr;
      logic [15:0] any;

      bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0; bus.swap_req = 1'b0;
      CLR = 1'b1;
      repeat (3) @(negedge CLK1_50);
      chk_reset_outputs("reset");
      CLR = 1'b0;
      model_reset();

      // Fill the back buffer without swapping: two frames stay blank.
      run_frame(2, -1, 4'd0, 16'h0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0);
      any = '0;
      for (int r = 0; r < 16; r++) any |= cap_col[r];
      chk("blank_first_frame", 32'(any), 32'(0));
      run_frame(0, -1, 4'd0, 16'h0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0);
      any = '0;
      for (int r = 0; r < 16; r++) any |= cap_col[r];
      chk("blank_no_swap_1", 32'(any), 32'(0));

      // Write row 3 and request a swap; still blank this frame.
      run_frame(0, 0, 4'd3, 16'hA5C3, 16'h0002, 1'b0, 1'b0, 4'd0, 16'h0);
      any = '0;
      for (int r = 0; r < 16; r++) any |= cap_col[r];
      chk("blank_no_swap_2", 32'(any), 32'(0));

      // Two requests coalesce; boundary-cycle write of row 0 shows next frame.
      run_frame(1, -1, 4'd0, 16'h0, 16'h0204, 1'b0, 1'b1, 4'd0, 16'h8001);
      chk("row3_pattern", 32'(cap_col[3]), 32'hA5C3);

      // Request asserted in the boundary cycle arms the following frame.
      run_frame(0, -1, 4'd0, 16'h0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0);
      chk("row0_boundary_write", 32'(cap_col[0]), 32'h8001);
      run_frame(1, -1, 4'd0, 16'h0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0);
      run_frame(1, -1, 4'd0, 16'h0, 16'($urandom) & 16'h7FFF, 1'b0, 1'b1,
                4'($urandom_range(0, 15)), 16'($urandom));
      run_frame(1, -1, 4'd0, 16'h0, 16'h0010, 1'b0, 1'b0, 4'd0, 16'h0);

      // Mid-scan reset during the ninth shifted bit of row 5.
      for (int r = 0; r < 5; r++) run_row(1'b0, 4'd0, 16'h0, 1'b0);
      rises = 0;
      prev_sr = bus.SRCLK;
      for (int i = 0; i < 4 * int'(ROW_PERIOD) && rises < 9; i++) begin
         tick();
         if (bus.SRCLK === 1'b1 && prev_sr === 1'b0) rises++;
         prev_sr = bus.SRCLK;
      end
      chk("reached_bit9", 32'(rises), 32'(9));
      chk("srclk_high_before_reset", 32'(bus.SRCLK), 32'(1));
      #2 CLR = 1'b1;
      #1 chk_reset_outputs("mid_reset");
      repeat (2) @(negedge CLK1_50);
      CLR = 1'b0;
      model_reset();

      run_frame(0, -1, 4'd0, 16'h0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0);
      any = '0;
      for (int r = 0; r < 16; r++) any |= cap_col[r];
      chk("blank_after_reset", 32'(any), 32'(0));
      run_frame(1, -1, 4'd0, 16'h0, 16'h0100, 1'b0, 1'b0, 4'd0, 16'h0);
      run_frame(1, -1, 4'd0, 16'h0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
